// File: rtl/dram_arb_pkg.sv
// Shared encodings and widths for the two-port DRAM command arbiter.
package dram_arb_pkg;
  localparam int DATA_W    = 144;
  localparam int BE_W      = 18;
  localparam int ADDR_W    = 32;
  localparam int NUM_PORTS = 2;

  localparam logic PORT_APP   = 1'b0;
  localparam logic PORT_SNIFF = 1'b1;

  typedef enum logic [1:0] {IDLE, GRANT, WR2} arb_state_e;

  typedef struct packed {
    logic              en;
    logic              rnw;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
  } port_req_t;
endpackage

// File: rtl/dram_arb_tag_fifo.sv
// DEPTH x 1-bit FIFO holding the issuing port of each outstanding read.
module dram_arb_tag_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  // A push at full is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/dram_cmd_arbiter.sv
// Shares one DRAM command interface between port 0 (app) and port 1 (sniffer).
// Define DRAM_ARB_RR_EN for round-robin on contention; default is port-0 priority.
module dram_cmd_arbiter
  import dram_arb_pkg::*;
#(
  parameter int RD_FIFO_DEPTH = 8,
  parameter int RD_BEATS      = 2
) (
  input  logic          dram_clk,
  input  logic          dram_rst_n,
  input  logic          p0_cmd_en,
  input  logic          p0_cmd_rnw,
  input  logic [31:0]   p0_address,
  input  logic [143:0]  p0_wr_data,
  input  logic [17:0]   p0_wr_be,
  output logic          p0_ack,
  output logic [143:0]  p0_rd_data,
  output logic          p0_rd_dvld,
  input  logic          p1_cmd_en,
  input  logic          p1_cmd_rnw,
  input  logic [31:0]   p1_address,
  input  logic [143:0]  p1_wr_data,
  input  logic [17:0]   p1_wr_be,
  output logic          p1_ack,
  output logic [143:0]  p1_rd_data,
  output logic          p1_rd_dvld,
  output logic          dram_cmd_en,
  output logic          dram_cmd_rnw,
  output logic [31:0]   dram_address,
  output logic [143:0]  dram_wr_data,
  output logic [17:0]   dram_wr_be,
  input  logic          dram_ack,
  input  logic [143:0]  dram_rd_data,
  input  logic          dram_rd_dvld,
  output logic          rd_orphan
);
  localparam int BW = $clog2(RD_BEATS + 1);

  arb_state_e                  state, state_nxt;
  logic                        grant, grant_nxt, last_grant, last_grant_nxt;
  logic [BW-1:0]               beat_cnt;
  port_req_t [NUM_PORTS-1:0]   req;
  port_req_t                   sel;
  logic [NUM_PORTS-1:0]        elig, ack_v, dvld_v;
  logic                        ack, push, pop, last_beat;
  logic                        fifo_full, fifo_empty, fifo_head;

  assign req[0] = {p0_cmd_en, p0_cmd_rnw, p0_address, p0_wr_data, p0_wr_be};
  assign req[1] = {p1_cmd_en, p1_cmd_rnw, p1_address, p1_wr_data, p1_wr_be};
  assign sel    = req[grant];

  // Eligibility sees the registered FIFO count, so a same-cycle pop helps next cycle.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign elig[i]   = req[i].en && (!req[i].rnw || !fifo_full);
    assign ack_v[i]  = ack && (grant == 1'(i));
    assign dvld_v[i] = dram_rd_dvld && !fifo_empty && (fifo_head == 1'(i));
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    push           = 1'b0;
    ack            = 1'b0;
    dram_cmd_en    = 1'b0;
    dram_wr_be     = '0;
    unique case (state)
      IDLE: begin
        if (|elig) begin
          state_nxt = GRANT;
          if (&elig) begin
`ifdef DRAM_ARB_RR_EN
            grant_nxt = ~last_grant;
`else
            grant_nxt = PORT_APP;
`endif
          end else begin
            grant_nxt = elig[PORT_SNIFF];
          end
        end
      end
      GRANT: begin
        dram_cmd_en = sel.en;
        dram_wr_be  = sel.wr_be;
        if (!sel.en) begin
          state_nxt = IDLE;
        end else if (dram_ack) begin
          ack            = 1'b1;
          last_grant_nxt = grant;
          push           = sel.rnw;
          state_nxt      = sel.rnw ? IDLE : WR2;
        end
      end
      WR2: begin
        dram_wr_be = sel.wr_be;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dram_cmd_rnw = sel.rnw;
  assign dram_address = sel.address;
  assign dram_wr_data = sel.wr_data;
  assign p0_ack       = ack_v[0];
  assign p1_ack       = ack_v[1];
  assign p0_rd_dvld   = dvld_v[0];
  assign p1_rd_dvld   = dvld_v[1];
  assign p0_rd_data   = dram_rd_data;
  assign p1_rd_data   = dram_rd_data;

  assign last_beat = (beat_cnt == BW'(RD_BEATS - 1));
  assign pop       = dram_rd_dvld && !fifo_empty && last_beat;

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      state      <= IDLE;
      grant      <= 1'b1;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      rd_orphan  <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      if (dram_rd_dvld && !fifo_empty) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      if (dram_rd_dvld && fifo_empty) rd_orphan <= 1'b1;
    end
  end

  dram_arb_tag_fifo #(.DEPTH(RD_FIFO_DEPTH)) u_tag_fifo (
    .clk   (dram_clk),
    .rst_n (dram_rst_n),
    .push  (push),
    .din   (grant),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );
endmodule
